fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 11 +
 rtl/fetch_queue.sv | 86 ++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Instruction-memory read port between the fetch queue (master) and memory (slave).
// Handshake: req=1 issues a read at addr; memory answers with rvalid=1 and rdata exactly one cycle later, in order, with no backpressure.
interface fetch_queue_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction queue: issues sequential reads under a credit rule and
// presents the oldest {address, word} to decode, with redirect flushing everything.
module fetch_queue #(
  parameter logic [31:0] InitAddress = 32'h0000_0000,
  parameter int          Depth       = 4,
  parameter logic [31:0] NopWord     = 32'h0000_0015
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    load_bubble,
  input  logic                    redirect,
  input  logic [31:0]             RedirectTarget,
  fetch_queue_if.master           imem,
  output logic [31:0]             Instr,
  output logic [31:0]             PCPlusFour,
  output logic                    InstrValid,
  output logic [$clog2(Depth):0]  Count
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  typedef logic [CntW-1:0] cnt_t;

  logic [31:0]     pc;
  logic [31:0]     req_addr;
  logic [31:0]     addr_mem [Depth];
  logic [31:0]     word_mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  cnt_t            count;
  logic            inflight;
  logic            drop;
  logic            credit;
  logic            push;
  logic            pop;

  // The outstanding read reserves a slot, so a returning word always has room.
  assign credit   = (count + cnt_t'(inflight)) < cnt_t'(Depth);
  assign imem.req  = reset & ~redirect & credit;
  assign imem.addr = pc;

  assign push = imem.rvalid & inflight & ~drop & ~redirect;
  assign pop  = (count != '0) & ~stall & ~load_bubble & ~redirect;

  assign InstrValid = (count != '0) & ~load_bubble;
  assign Instr      = InstrValid ? word_mem[rd_ptr] : NopWord;
  assign PCPlusFour = InstrValid ? addr_mem[rd_ptr] + 32'd4 : 32'd0;
  assign Count      = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= InitAddress;
      req_addr <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= imem.req;
      drop     <= redirect;
      if (redirect) begin
        pc     <= RedirectTarget;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (imem.req) begin
          pc       <= pc + 32'd4;
          req_addr <= pc;
        end
        if (push) wr_ptr <= wr_ptr + PtrW'(1);
        if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // Storage needs no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_addr;
      word_mem[wr_ptr] <= imem.rdata;
    end
  end
endmodule
